// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   rx_state_t  - receiver FSM state encoding
//   calc_div    - baud-tick divisor from clock rate, bit rate and oversampling
//   cnt_width   - register width needed to hold a count of 0..n-1 (min 1)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divide-by-DIV counter producing a one-clock tick.
// Ports:
//   clock  - system clock
//   nreset - asynchronous active-low reset
//   tick   - high for one clock each time the counter wraps from DIV-1 to 0
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic nreset,
  output logic tick
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive channel with oversampled start-bit validation.
// Ports:
//   clock       - system clock
//   nreset      - asynchronous active-low reset
//   sdata       - serial line (asynchronous, idle high)
//   data        - last correctly received byte
//   valid       - one-clock pulse when a good frame completes
//   frame_error - one-clock pulse when the stop bit is sampled low
//   busy        - high whenever the receiver is not idle
//
// state     | meaning
// IDLE      | line idle, looking for a low level on a tick
// START     | start bit seen, confirming it is still low at mid-bit
// DATA      | sampling data bits at their centres, LSB first
// STOP      | waiting for the stop-bit centre to check it is high
// WAIT_IDLE | bad stop bit, holding off until the line goes high again
module uart_rx
  import uart_pkg::*;
#(
  parameter int BYTESIZES           = 8,
  parameter int OVERSAMPLING        = 16,
  parameter int BAUDRATE            = 115200,
  parameter int COUNTER_CLOCK_INPUT = 50_000_000
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 sdata,
  output logic [BYTESIZES-1:0] data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int DIV = calc_div(COUNTER_CLOCK_INPUT, BAUDRATE, OVERSAMPLING);
  localparam int SW  = cnt_width(OVERSAMPLING);
  localparam int BW  = cnt_width(BYTESIZES);

  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BYTESIZES - 1);

  logic tick;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clock (clock),
    .nreset(nreset),
    .tick  (tick)
  );

  logic sync_1;
  logic rx_s;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= sdata;
      rx_s   <= sync_1;
    end
  end

  rx_state_t            state, state_nxt;
  logic [SW-1:0]        sample_cnt, sample_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [BYTESIZES-1:0] shreg, shreg_nxt;
  logic [BYTESIZES-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      sample_cnt  <= sample_nxt;
      bit_cnt     <= bit_nxt;
      shreg       <= shreg_nxt;
      data        <= data_nxt;
      valid       <= valid_nxt;
      frame_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sample_nxt = sample_cnt;
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    data_nxt   = data;
    valid_nxt  = 1'b0;
    ferr_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (tick && !rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (tick) begin
          if (sample_cnt == HALF_LAST) begin
            // a start bit that is already high again at mid-bit was a glitch
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sample_cnt == FULL_LAST) begin
            // widen by one bit before shifting so a 1-bit frame still works
            shreg_nxt  = BYTESIZES'({rx_s, shreg} >> 1);
            bit_nxt    = bit_cnt + BW'(1);
            sample_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (sample_cnt == FULL_LAST) begin
            if (rx_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end

      WAIT_IDLE: begin
        if (tick && rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // every state starts its own tick and bit count from zero
    if (state_nxt != state) begin
      sample_nxt = '0;
      bit_nxt    = '0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// outcome of each frame (good byte or framing error) into a queue; a monitor
// pops and compares whenever the receiver strobes.
module tb_uart_rx;

  localparam int BIT_CLKS = (50_000_000 / (115200 * 16)) * 16;

  typedef struct {
    bit         is_err;
    logic [7:0] byte_v;
  } exp_t;

  logic       clock  = 1'b0;
  logic       nreset = 1'b0;
  logic       sdata  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  uart_rx dut (
    .clock      (clock),
    .nreset     (nreset),
    .sdata      (sdata),
    .data       (data),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  int   valid_cyc[$];
  logic [7:0] last_good = 8'h00;
  exp_t mon_e;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (nreset && (valid || frame_error)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: valid=%0b frame_error=%0b at cycle %0d, expected no strobe",
                 valid, frame_error, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind", {30'd0, valid, frame_error}, mon_e.is_err ? 32'd1 : 32'd2);
        if (!mon_e.is_err) begin
          chk("rx_data", {24'd0, data}, {24'd0, mon_e.byte_v});
          chk("busy_low_on_valid", {31'd0, busy}, 32'd0);
          last_good = mon_e.byte_v;
          valid_cyc.push_back(cyc);
        end else begin
          chk("err_data_hold", {24'd0, data}, {24'd0, last_good});
          chk("busy_high_on_err", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic idle(input int n);
    sdata = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // line waveform of one frame: start 0, data LSB first, stop
  task automatic send_frame(input logic [7:0] b, input bit stop, input int per);
    exp_t e;
    logic [9:0] line;
    e.is_err = !stop;
    e.byte_v = b;
    exp_q.push_back(e);
    line = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sdata = line[i];
      repeat (per) @(negedge clock);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < BIT_CLKS / 4) begin
      @(negedge clock);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #(120_000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    bit         rstop;
    int         rper;
    int         d;

    nreset = 1'b0;
    sdata  = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    nreset = 1'b1;
    idle(BIT_CLKS);

    // single frame
    valid_cyc.delete();
    send_frame(8'hA5, 1'b1, BIT_CLKS);
    drain("t1_drain");
    chk("t1_valid_count", valid_cyc.size(), 1);
    idle(BIT_CLKS);

    // back-to-back, no idle gap
    valid_cyc.delete();
    send_frame(8'h00, 1'b1, BIT_CLKS);
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    drain("t2_drain");
    chk("t2_valid_count", valid_cyc.size(), 2);
    if (valid_cyc.size() == 2) begin
      d = valid_cyc[1] - valid_cyc[0];
      chk("t2_spacing", {31'd0, (d >= 10 * BIT_CLKS - 27) && (d <= 10 * BIT_CLKS + 27)}, 32'd1);
    end
    idle(BIT_CLKS);

    // short low glitch
    sdata = 1'b0;
    repeat (100) @(negedge clock);
    chk("t3_busy_in_glitch", {31'd0, busy}, 32'd1);
    repeat (50) @(negedge clock);
    idle(BIT_CLKS - 150);
    chk("t3_busy_after", {31'd0, busy}, 32'd0);
    idle(BIT_CLKS);

    // bad stop bit followed by a break, then a good frame
    send_frame(8'h3C, 1'b0, BIT_CLKS);
    drain("t4_drain_err");
    sdata = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clock);
    chk("t4_busy_in_break", {31'd0, busy}, 32'd1);
    idle(BIT_CLKS);
    chk("t4_busy_after_break", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, BIT_CLKS);
    drain("t4_drain_good");
    idle(BIT_CLKS);

    // reset in the middle of data bit 4 of 0x81
    begin
      logic [9:0] line;
      line = {1'b1, 8'h81, 1'b0};
      for (int i = 0; i < 5; i++) begin
        sdata = line[i];
        repeat (BIT_CLKS) @(negedge clock);
      end
      sdata = line[5];
      repeat (BIT_CLKS / 2) @(negedge clock);
    end
    nreset = 1'b0;
    @(negedge clock);
    chk("t5_rst_data", {24'd0, data}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_valid", {31'd0, valid}, 32'd0);
    last_good = 8'h00;
    sdata = 1'b1;
    repeat (5) @(negedge clock);
    nreset = 1'b1;
    idle(BIT_CLKS);
    send_frame(8'h42, 1'b1, BIT_CLKS);
    drain("t5_drain");
    idle(BIT_CLKS);

    // +-3% baud skew
    send_frame(8'h96, 1'b1, 419);
    drain("t6_drain_fast");
    idle(BIT_CLKS);
    send_frame(8'h96, 1'b1, 445);
    drain("t6_drain_slow");
    idle(BIT_CLKS);

    // randomized frames with skew, gaps and occasional bad stop bits
    for (int n = 0; n < 4; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rper  = $urandom_range(419, 445);
      send_frame(rb, rstop, rper);
      drain("rand_drain");
      if (!rstop) begin
        sdata = 1'b0;
        repeat ($urandom_range(0, BIT_CLKS)) @(negedge clock);
        idle(BIT_CLKS + $urandom_range(0, BIT_CLKS / 2));
      end else begin
        idle($urandom_range(0, BIT_CLKS / 2));
      end
    end
    idle(2 * BIT_CLKS);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive channel of the UART. It is the stage directly downstream of the TX serialiser on the serial link.
- Samples the asynchronous serial line using an oversampled baud tick and validates the start bit.
- Shifts in BYTESIZES data bits, LSB first, then checks the stop bit.
- Presents each received byte with a one-cycle valid strobe, or with a framing-error strobe.
- Frame format: idle high, one start bit (0), BYTESIZES data bits LSB first, one stop bit (1).

Parameters:
- BYTESIZES, 8: data bits per frame.
- OVERSAMPLING, 16: baud ticks per bit period. Must be even and ≥4.
- BAUDRATE, 115200: line bit rate.
- COUNTER_CLOCK_INPUT, 50_000_000: clock frequency in Hz.
- Derived tick divisor DIV = COUNTER_CLOCK_INPUT/(BAUDRATE*OVERSAMPLING), truncated. DIV must be ≥1.

Ports:
- clock, input, 1: system clock. All logic on posedge.
- nreset, input, 1: asynchronous active-low reset.
- sdata, input, 1: serial line, asynchronous to clock.
- data, output, BYTESIZES: last received byte.
- valid, output, 1: one-clock pulse when a good frame completes.
- frame_error, output, 1: one-clock pulse when the stop bit is sampled as 0.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, nreset=0):
  - data=0, valid=0, frame_error=0, busy=0.
  - Synchroniser flops =1. FSM=IDLE. Tick, sample and bit counters =0.
- Synchroniser: two flops on sdata; all logic uses the second flop (rx_s). Input-to-FSM latency is 2 clocks.
- Baud tick: a free-running counter 0..DIV-1 pulses tick for one clock when it wraps. It runs continuously and is not re-aligned on the start edge.
- Sample counter: counts ticks 0..OVERSAMPLING-1 within a bit and is cleared on every state change.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a tick with rx_s=0, go to START.
  - START: on the tick where the sample counter reaches OVERSAMPLING/2-1 (mid-bit):
    - rx_s=0: go to DATA.
    - rx_s=1: treat as a glitch and return to IDLE with no strobe.
  - DATA: every OVERSAMPLING ticks (bit centre), shift rx_s into the MSB of the shift register, shifting right, and increment the bit counter. After BYTESIZES bits, go to STOP.
  - STOP: after OVERSAMPLING ticks, sample rx_s.
    - rx_s=1: data<=shift register, valid=1 for exactly one clock, go to IDLE.
    - rx_s=0: frame_error=1 for one clock, data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1 on a tick, then go to IDLE. This prevents a break condition from being decoded as frames.
- Timing and strobes:
  - valid and frame_error are never high together.
  - The strobes fire at the stop-bit centre, so a back-to-back start bit is caught within half a bit.
  - data holds its value until the next good frame. There is no backpressure; a consumer that misses the pulse loses the byte.
- Tolerance: the start bit must be low at mid-bit. A low pulse shorter than OVERSAMPLING/2 ticks is rejected.
- Reset mid-frame: returns immediately to the reset state. No strobe is emitted, and the partial byte is discarded.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - a function computing DIV from the clock, BAUDRATE and OVERSAMPLING;
  - a function computing counter widths (clog2).
- Sub-module uart_baud_tick, a parameterised DIV counter producing a one-clock tick. It is reusable by other UART blocks.
- The synchroniser and FSM are inline in uart_rx.

Test Plan:
1. Defaults (DIV=27, bit period 432 clocks); drive frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> exactly one valid pulse, data=0xA5, frame_error never high, busy falls with valid.
2. Back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses ~4320 clocks apart, data=0x00 then 0xFF.
3. Low glitch of 150 clocks (<8 ticks) on an idle line -> no valid, no frame_error, FSM returns to IDLE, busy low within 1 bit period.
4. Frame 0x3C with stop bit driven 0, line held low 3 bit periods, then high -> one frame_error pulse, no valid, data keeps its previous value, no further strobes until the line returns high; a following 0x5A is received correctly.
5. nreset asserted during bit 4 of frame 0x81, released and frame 0x42 sent -> no strobe for 0x81, valid with data=0x42.
6. Baud skew ±3% on 0x96 (bit period 419 and 445 clocks) -> valid with data=0x96 in both runs.
